// File: rtl/simon_iter_core.sv
// Iterative Simon block-cipher engine: one Feistel round per clock, encrypt or decrypt,
// with round keys fetched combinationally from an external store by round index.

module simon_round #(
  parameter int WORD  = 16,
  parameter int ROT_A = 1,
  parameter int ROT_B = 8,
  parameter int ROT_C = 2
) (
  input  logic            decrypt,
  input  logic [WORD-1:0] u,
  input  logic [WORD-1:0] l,
  input  logic [WORD-1:0] key,
  output logic [WORD-1:0] u_nxt,
  output logic [WORD-1:0] l_nxt
);
  function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] x, input int n);
    int s;
    s = n % WORD;
    if (s == 0) return x;
    return (x << s) | (x >> (WORD - s));
  endfunction

  logic [WORD-1:0] src;
  logic [WORD-1:0] other;
  logic [WORD-1:0] mix;

  // Decrypt is the mirror image: f() reads the lower word and the halves swap roles.
  assign src   = decrypt ? l : u;
  assign other = decrypt ? u : l;
  assign mix   = ((rotl(src, ROT_A) & rotl(src, ROT_B)) ^ rotl(src, ROT_C)) ^ other ^ key;
  assign u_nxt = decrypt ? l : mix;
  assign l_nxt = decrypt ? mix : u;
endmodule

module simon_iter_core #(
  parameter int WORD   = 16,
  parameter int ROUNDS = 32,
  parameter int ROT_A  = 1,
  parameter int ROT_B  = 8,
  parameter int ROT_C  = 2,
  localparam int RIDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic [WORD-1:0]   u_in,
  input  logic [WORD-1:0]   l_in,
  input  logic [WORD-1:0]   subkey,
  output logic [RIDX_W-1:0] rnd_idx,
  output logic              busy,
  output logic              done,
  output logic [WORD-1:0]   u_out,
  output logic [WORD-1:0]   l_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [RIDX_W-1:0] IDX_LAST = RIDX_W'(ROUNDS - 1);
  localparam logic [RIDX_W-1:0] IDX_ONE  = RIDX_W'(1);

  state_t          state;
  state_t          state_nxt;
  logic            mode;
  logic            last;
  logic [WORD-1:0] u_r;
  logic [WORD-1:0] l_r;
  logic [WORD-1:0] u_nxt;
  logic [WORD-1:0] l_nxt;

  simon_round #(
    .WORD (WORD),
    .ROT_A(ROT_A),
    .ROT_B(ROT_B),
    .ROT_C(ROT_C)
  ) u_round (
    .decrypt(mode),
    .u      (u_r),
    .l      (l_r),
    .key    (subkey),
    .u_nxt  (u_nxt),
    .l_nxt  (l_nxt)
  );

  // Decrypt walks the key schedule downwards, so its final round is index 0.
  assign last = mode ? (rnd_idx == '0) : (rnd_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_r     <= '0;
      l_r     <= '0;
      mode    <= 1'b0;
      rnd_idx <= '0;
      u_out   <= '0;
      l_out   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          u_r     <= u_in;
          l_r     <= l_in;
          mode    <= decrypt;
          rnd_idx <= decrypt ? IDX_LAST : '0;
        end
        RUN: begin
          u_r <= u_nxt;
          l_r <= l_nxt;
          // The index parks on the final value rather than wrapping.
          if (last) begin
            u_out <= u_nxt;
            l_out <= l_nxt;
          end else begin
            rnd_idx <= mode ? rnd_idx - IDX_ONE : rnd_idx + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_iter_core.sv
// Bench for simon_iter_core: Simon32/64 and Simon64/128 vectors, single-round core,
// handshake timing, mid-block reset; expected blocks queued at start, checked at done.

module tb_simon_iter_core;
  localparam int R32 = 32;
  localparam int R64 = 44;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] ks32 [0:31];
  logic [31:0] ks64 [0:63];
  logic [63:0] kx   [0:63];

  typedef struct {
    logic [31:0] u;
    logic [31:0] l;
  } exp_t;
  exp_t sb[$];

  // Simon32/64 core
  logic        a_start, a_dec, a_busy, a_done;
  logic [15:0] a_u_in, a_l_in, a_sk, a_u_out, a_l_out;
  logic [4:0]  a_idx;
  assign a_sk = ks32[a_idx];

  simon_iter_core dut_a (
    .clk(clk), .rst(rst), .start(a_start), .decrypt(a_dec), .u_in(a_u_in), .l_in(a_l_in),
    .subkey(a_sk), .rnd_idx(a_idx), .busy(a_busy), .done(a_done), .u_out(a_u_out), .l_out(a_l_out)
  );

  // Single-round core with a zero key
  logic        b_start, b_dec, b_busy, b_done;
  logic [15:0] b_u_in, b_l_in, b_sk, b_u_out, b_l_out;
  logic [0:0]  b_idx;
  assign b_sk = 16'h0000;

  simon_iter_core #(.WORD(16), .ROUNDS(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .decrypt(b_dec), .u_in(b_u_in), .l_in(b_l_in),
    .subkey(b_sk), .rnd_idx(b_idx), .busy(b_busy), .done(b_done), .u_out(b_u_out), .l_out(b_l_out)
  );

  // Simon64/128 core
  logic        c_start, c_dec, c_busy, c_done;
  logic [31:0] c_u_in, c_l_in, c_sk, c_u_out, c_l_out;
  logic [5:0]  c_idx;
  assign c_sk = ks64[c_idx];

  simon_iter_core #(.WORD(32), .ROUNDS(44)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .decrypt(c_dec), .u_in(c_u_in), .l_in(c_l_in),
    .subkey(c_sk), .rnd_idx(c_idx), .busy(c_busy), .done(c_done), .u_out(c_u_out), .l_out(c_l_out)
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((x >> r) | (x << (w - r))) & m;
  endfunction

  // Reference Simon key expansion for m = 4 key words
  task automatic expand(input int w, input int t, input logic [61:0] z,
                        input logic [63:0] k0, input logic [63:0] k1,
                        input logic [63:0] k2, input logic [63:0] k3);
    logic [63:0] m, tmp;
    m = (64'd1 << w) - 64'd1;
    kx[0] = k0; kx[1] = k1; kx[2] = k2; kx[3] = k3;
    for (int i = 4; i < t; i++) begin
      tmp   = rotr(kx[i-1], 3, w) ^ kx[i-3];
      tmp   = tmp ^ rotr(tmp, 1, w);
      kx[i] = (~kx[i-4] & m) ^ tmp ^ 64'(z[61 - ((i - 4) % 62)]) ^ 64'd3;
    end
  endtask

  function automatic logic [15:0] f16(input logic [15:0] x);
    return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
  endfunction

  function automatic logic [31:0] model32(input logic [15:0] u0, input logic [15:0] l0, input bit dec);
    logic [15:0] u, l, t;
    u = u0; l = l0;
    for (int r = 0; r < R32; r++) begin
      if (!dec) begin
        t = u; u = f16(u) ^ l ^ ks32[r]; l = t;
      end else begin
        t = l; l = f16(l) ^ u ^ ks32[R32-1-r]; u = t;
      end
    end
    return {u, l};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    a_start = 0; a_dec = 0; a_u_in = '0; a_l_in = '0;
    b_start = 0; b_dec = 0; b_u_in = '0; b_l_in = '0;
    c_start = 0; c_dec = 0; c_u_in = '0; c_l_in = '0;
    #1;
    checks++; if ({a_u_out, a_l_out} !== 32'h0) begin failures++; $display("FAIL reset_a_out: got %h expected 0", {a_u_out, a_l_out}); end
    checks++; if ({a_idx, a_busy, a_done} !== 7'h0) begin failures++; $display("FAIL reset_a_ctl: got %h expected 0", {a_idx, a_busy, a_done}); end
    checks++; if ({c_u_out, c_l_out, c_idx, c_busy, c_done} !== 72'h0) begin failures++; $display("FAIL reset_c: got %h expected 0", {c_u_out, c_l_out, c_idx, c_busy, c_done}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({a_busy, a_done, b_busy, b_done, c_busy, c_done} !== 6'h0) begin failures++; $display("FAIL post_reset_idle: got %b expected 0", {a_busy, a_done, b_busy, b_done, c_busy, c_done}); end
  endtask

  task automatic test_single_round(input bit dec, input logic [15:0] u, input logic [15:0] l,
                                   input logic [15:0] eu, input logic [15:0] el);
    exp_t e;
    b_dec = dec; b_u_in = u; b_l_in = l;
    e.u = {16'h0, eu}; e.l = {16'h0, el}; sb.push_back(e);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    checks++; if ({b_busy, b_done, b_idx} !== 3'b100) begin failures++; $display("FAIL single_run_state dec=%0d: got %b expected 100", dec, {b_busy, b_done, b_idx}); end
    @(negedge clk);
    checks++; if ({b_busy, b_done, b_idx} !== 3'b010) begin failures++; $display("FAIL single_done_state dec=%0d: got %b expected 010", dec, {b_busy, b_done, b_idx}); end
    e = sb.pop_front();
    checks++; if ({b_u_out, b_l_out} !== {e.u[15:0], e.l[15:0]}) begin failures++; $display("FAIL single_result dec=%0d: got %h expected %h", dec, {b_u_out, b_l_out}, {e.u[15:0], e.l[15:0]}); end
    @(negedge clk);
    checks++; if (b_done !== 1'b0) begin failures++; $display("FAIL single_done_width dec=%0d: got %b expected 0", dec, b_done); end
  endtask

  task automatic test_simon32(input bit dec);
    exp_t e;
    int k, bad;
    a_dec  = dec;
    a_u_in = dec ? 16'hc69b : 16'h6565;
    a_l_in = dec ? 16'he9bb : 16'h6877;
    e.u = dec ? 32'h6565 : 32'hc69b;
    e.l = dec ? 32'h6877 : 32'he9bb;
    sb.push_back(e);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    k = 0; bad = 0;
    while (!a_done && k < R32 + 8) begin
      if (a_idx !== (dec ? 5'(R32 - 1 - k) : 5'(k))) bad++;
      if (a_busy !== 1'b1) bad++;
      @(negedge clk); k++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL s32_idx_seq dec=%0d: got %0d bad cycles expected 0", dec, bad); end
    checks++; if (k != R32) begin failures++; $display("FAIL s32_latency dec=%0d: got %0d expected %0d", dec, k, R32); end
    e = sb.pop_front();
    checks++; if ({a_u_out, a_l_out} !== {e.u[15:0], e.l[15:0]}) begin failures++; $display("FAIL s32_result dec=%0d: got %h expected %h", dec, {a_u_out, a_l_out}, {e.u[15:0], e.l[15:0]}); end
    checks++; if (a_idx !== (dec ? 5'd0 : 5'd31)) begin failures++; $display("FAIL s32_idx_hold dec=%0d: got %0d expected %0d", dec, a_idx, dec ? 0 : 31); end
    @(negedge clk);
    checks++; if ({a_done, a_busy} !== 2'b00) begin failures++; $display("FAIL s32_after_done dec=%0d: got %b expected 00", dec, {a_done, a_busy}); end
  endtask

  task automatic test_reset_mid_block;
    int k, bad;
    a_dec = 1'b0; a_u_in = 16'h6565; a_l_in = 16'h6877;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    k = 0;
    while (a_idx !== 5'd10 && k < R32 + 8) begin @(negedge clk); k++; end
    checks++; if (a_idx !== 5'd10) begin failures++; $display("FAIL midrst_reach: got %0d expected 10", a_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_u_out, a_l_out} !== 32'h0) begin failures++; $display("FAIL midrst_out: got %h expected 0", {a_u_out, a_l_out}); end
    checks++; if ({a_idx, a_busy, a_done} !== 7'h0) begin failures++; $display("FAIL midrst_ctl: got %h expected 0", {a_idx, a_busy, a_done}); end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (R32 + 4) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_simon64(input bit dec);
    exp_t e;
    int k, bad;
    c_dec  = dec;
    c_u_in = dec ? 32'h44c8fc20 : 32'h656b696c;
    c_l_in = dec ? 32'hb9dfa07a : 32'h20646e75;
    e.u = dec ? 32'h656b696c : 32'h44c8fc20;
    e.l = dec ? 32'h20646e75 : 32'hb9dfa07a;
    sb.push_back(e);
    @(negedge clk); c_start = 1'b1;
    @(negedge clk); c_start = 1'b0;
    k = 0; bad = 0;
    while (!c_done && k < R64 + 8) begin
      if (c_idx !== (dec ? 6'(R64 - 1 - k) : 6'(k))) bad++;
      @(negedge clk); k++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL s64_idx_seq dec=%0d: got %0d bad cycles expected 0", dec, bad); end
    checks++; if (k != R64) begin failures++; $display("FAIL s64_latency dec=%0d: got %0d expected %0d", dec, k, R64); end
    e = sb.pop_front();
    checks++; if ({c_u_out, c_l_out} !== {e.u, e.l}) begin failures++; $display("FAIL s64_result dec=%0d: got %h expected %h", dec, {c_u_out, c_l_out}, {e.u, e.l}); end
  endtask

  task automatic test_handshake;
    exp_t e;
    int ndone, first, second, bad;
    a_dec = 1'b0; a_u_in = 16'h6565; a_l_in = 16'h6877;
    e.u = 32'hc69b; e.l = 32'he9bb;
    sb.push_back(e); sb.push_back(e);
    ndone = 0; first = -1; second = -1; bad = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc <= 2 * R32 + 2; cyc++) begin
      if (cyc == 2 * R32 + 2) a_start = 1'b0;
      if (cyc == R32 + 1 && a_busy !== 1'b0) bad++;
      if (cyc == R32 + 2 && a_busy !== 1'b1) bad++;
      if (a_done === 1'b1) begin
        if (ndone == 0) first = cyc; else if (ndone == 1) second = cyc;
        ndone++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL hs_result: got unexpected done at cycle %0d", cyc); end
        else begin
          e = sb.pop_front();
          if ({a_u_out, a_l_out} !== {e.u[15:0], e.l[15:0]}) begin failures++; $display("FAIL hs_result: got %h expected %h", {a_u_out, a_l_out}, {e.u[15:0], e.l[15:0]}); end
        end
      end
      if (cyc != 2 * R32 + 2) @(negedge clk);
    end
    checks++; if (ndone != 2) begin failures++; $display("FAIL hs_count: got %0d expected 2", ndone); end
    checks++; if (first != R32 || second != 2 * R32 + 2) begin failures++; $display("FAIL hs_spacing: got %0d,%0d expected %0d,%0d", first, second, R32, 2 * R32 + 2); end
    checks++; if (bad != 0) begin failures++; $display("FAIL hs_done_ignores_start: got %0d bad cycles expected 0", bad); end
    repeat (2) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL hs_stop: got busy %b expected 0", a_busy); end
    sb.delete();
  endtask

  task automatic test_inputs_change;
    exp_t e;
    int k, bad;
    a_dec = 1'b1; a_u_in = 16'hc69b; a_l_in = 16'he9bb;
    e.u = 32'h6565; e.l = 32'h6877; sb.push_back(e);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    k = 0;
    while (!a_done && k < R32 + 8) begin
      a_u_in = 16'($urandom); a_l_in = 16'($urandom); a_dec = 1'($urandom);
      @(negedge clk); k++;
    end
    checks++; if (k != R32) begin failures++; $display("FAIL chg_latency: got %0d expected %0d", k, R32); end
    e = sb.pop_front();
    checks++; if ({a_u_out, a_l_out} !== {e.u[15:0], e.l[15:0]}) begin failures++; $display("FAIL chg_result: got %h expected %h", {a_u_out, a_l_out}, {e.u[15:0], e.l[15:0]}); end
    bad = 0;
    repeat (6) begin
      a_u_in = 16'($urandom); a_l_in = 16'($urandom); a_dec = 1'($urandom);
      @(negedge clk);
      if ({a_u_out, a_l_out} !== 32'h65656877 || a_done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL out_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [15:0] pu, pl;
    logic [31:0] r;
    bit pd;
    int k;
    for (int blk = 0; blk < 3; blk++) begin
      pu = 16'($urandom); pl = 16'($urandom); pd = 1'($urandom);
      r = model32(pu, pl, pd);
      e.u = {16'h0, r[31:16]}; e.l = {16'h0, r[15:0]}; sb.push_back(e);
      a_u_in = pu; a_l_in = pl; a_dec = pd;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      k = 0;
      while (!a_done && k < R32 + 8) begin @(negedge clk); k++; end
      checks++; if (k != R32) begin failures++; $display("FAIL b2b_latency blk=%0d: got %0d expected %0d", blk, k, R32); end
      e = sb.pop_front();
      checks++; if ({a_u_out, a_l_out} !== {e.u[15:0], e.l[15:0]}) begin failures++; $display("FAIL b2b_result blk=%0d: got %h expected %h", blk, {a_u_out, a_l_out}, {e.u[15:0], e.l[15:0]}); end
      if (blk == 0) begin
        a_start = 1'b1; a_u_in = 16'($urandom);
        @(negedge clk); a_start = 1'b0;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done: got busy %b expected 0", a_busy); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    expand(16, R32, Z0, 64'h0100, 64'h0908, 64'h1110, 64'h1918);
    for (int i = 0; i < R32; i++) ks32[i] = kx[i][15:0];
    expand(32, R64, Z3, 64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918);
    for (int i = 0; i < 64; i++) ks64[i] = (i < R64) ? kx[i][31:0] : 32'h0;

    test_reset;
    test_single_round(1'b0, 16'h0001, 16'h0000, 16'h0004, 16'h0001);
    test_single_round(1'b1, 16'h0004, 16'h0001, 16'h0001, 16'h0000);
    test_simon32(1'b0);
    test_simon32(1'b1);
    test_reset_mid_block;
    test_simon32(1'b0);
    test_simon64(1'b0);
    test_simon64(1'b1);
    test_handshake;
    test_inputs_change;
    test_back_to_back;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end
endmodule
